// File: rtl/growing_avg_pkg.sv
// Shared widths, helpers and state layout for the multichannel growing-sum averager.
// Build option: define ROUND_EN for round-half-up results (default truncates).
package growing_avg_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int MAX_LOG2_DEF = 7;

    function automatic int acc_w(input int data_w, input int max_log2);
        return data_w + max_log2;
    endfunction

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Per-channel state at the default configuration
    typedef struct packed {
        logic [DATA_W_DEF+MAX_LOG2_DEF-1:0]  acc;
        logic [MAX_LOG2_DEF-1:0]             cnt;
        logic [$clog2(MAX_LOG2_DEF+1)-1:0]   n_cur;
    } lane_st_t;

endpackage

// File: rtl/multichan_growing_avg_if.sv
// Sample-in / mean-out bundle of the multichannel averager.
// Build option: ROUND_EN (see growing_avg_pkg).
interface multichan_growing_avg_if
    import growing_avg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_CH     = 4,
    parameter int MAX_LOG2 = MAX_LOG2_DEF
);
    localparam int CH_W = ch_w(N_CH);
    localparam int NW   = $clog2(MAX_LOG2 + 1);

    logic              valid_in;
    logic [DATA_W-1:0] x;
    logic [CH_W-1:0]   ch_in;
    logic [NW-1:0]     n_avgs_in;
    logic              clear;
    logic              valid_out;
    logic [DATA_W-1:0] y;
    logic [CH_W-1:0]   ch_out;

    modport slave (
        input  valid_in, x, ch_in, n_avgs_in, clear,
        output valid_out, y, ch_out
    );

    modport master (
        output valid_in, x, ch_in, n_avgs_in, clear,
        input  valid_out, y, ch_out
    );

endinterface

// File: rtl/growing_avg_lane.sv
// One channel: accumulator, sample counter, latched block length and shift/round.
// Build option: ROUND_EN selects round-half-up instead of truncation.
module growing_avg_lane
    import growing_avg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOG2 = MAX_LOG2_DEF,
    localparam int ACC_W   = acc_w(DATA_W, MAX_LOG2),
    localparam int NW      = $clog2(MAX_LOG2 + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_x,
    input  logic [NW-1:0]     i_n,
    input  logic              i_clear,
    output logic              o_done,
    output logic [DATA_W-1:0] o_res
);

    typedef struct packed {
        logic [ACC_W-1:0]    acc;
        logic [MAX_LOG2-1:0] cnt;
        logic [NW-1:0]       n_cur;
    } st_t;

    st_t                 r_st;
    logic                w_start;
    logic [NW-1:0]       w_n;
    logic [ACC_W-1:0]    w_sum;
    logic [MAX_LOG2:0]   w_cnt;
    logic                w_last;
    logic [ACC_W:0]      w_rnd;

    // A clear restarts the block, so a same-cycle sample opens a fresh one
    always_comb begin
        w_start = i_clear || (r_st.cnt == '0);
        w_n     = r_st.n_cur;
        if (w_start) begin
            w_n = (i_n > NW'(MAX_LOG2)) ? NW'(MAX_LOG2) : i_n;
        end
        w_sum  = (w_start ? '0 : r_st.acc) + ACC_W'(i_x);
        w_cnt  = (w_start ? '0 : (MAX_LOG2+1)'(r_st.cnt))
               + (MAX_LOG2+1)'(1);
        w_last = (w_cnt == ((MAX_LOG2+1)'(1) << w_n));
`ifdef ROUND_EN
        w_rnd = (ACC_W+1)'(w_sum);
        if (w_n != '0) begin
            w_rnd = w_rnd + ((ACC_W+1)'(1) << (w_n - NW'(1)));
        end
`else
        w_rnd = (ACC_W+1)'(w_sum);
`endif
    end

    assign o_done = i_valid && w_last;
    assign o_res  = DATA_W'(w_rnd >> w_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st <= '0;
        end else if (i_valid) begin
            r_st.n_cur <= w_n;
            if (w_last) begin
                r_st.acc <= '0;
                r_st.cnt <= '0;
            end else begin
                r_st.acc <= w_sum;
                r_st.cnt <= w_cnt[MAX_LOG2-1:0];
            end
        end else if (i_clear) begin
            r_st.acc <= '0;
            r_st.cnt <= '0;
        end
    end

endmodule

// File: rtl/multichan_growing_avg.sv
// Time-interleaved per-channel block averager with decimated mean output.
// Build option: ROUND_EN selects round-half-up instead of truncation.
module multichan_growing_avg
    import growing_avg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_CH     = 4,
    parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multichan_growing_avg_if.slave  bus
);

    localparam int CH_W = ch_w(N_CH);

    logic [N_CH-1:0]   w_done;
    logic [DATA_W-1:0] w_res [N_CH];
    logic              w_any;
    logic [DATA_W-1:0] w_sel_y;
    logic [CH_W-1:0]   w_sel_ch;
    logic              r_valid;
    logic [DATA_W-1:0] r_y;
    logic [CH_W-1:0]   r_ch;

    // Indices at or above N_CH decode to no lane and are dropped
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        growing_avg_lane #(
            .DATA_W   (DATA_W),
            .MAX_LOG2 (MAX_LOG2)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (bus.valid_in && (bus.ch_in == CH_W'(g))),
            .i_x     (bus.x),
            .i_n     (bus.n_avgs_in),
            .i_clear (bus.clear),
            .o_done  (w_done[g]),
            .o_res   (w_res[g])
        );
    end

    always_comb begin
        w_any    = 1'b0;
        w_sel_y  = '0;
        w_sel_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_done[i]) begin
                w_any    = 1'b1;
                w_sel_y  = w_res[i];
                w_sel_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_ch    <= '0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_y  <= w_sel_y;
                r_ch <= w_sel_ch;
            end
        end
    end

    assign bus.valid_out = r_valid;
    assign bus.y         = r_y;
    assign bus.ch_out    = r_ch;

endmodule

// File: tb/tb_multichan_growing_avg.sv
// Scoreboard bench for multichan_growing_avg (5 channels so ch 5..7 are invalid).
// Build option: ROUND_EN changes the expected rounding result.
module tb_multichan_growing_avg;

    localparam int DATA_W   = 16;
    localparam int N_CH     = 5;
    localparam int MAX_LOG2 = 7;

    typedef struct {
        int ch;
        int y;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    exp_t q[$];

    multichan_growing_avg_if #(
        .DATA_W(DATA_W), .N_CH(N_CH), .MAX_LOG2(MAX_LOG2)
    ) bus ();

    multichan_growing_avg #(
        .DATA_W(DATA_W), .N_CH(N_CH), .MAX_LOG2(MAX_LOG2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input int ch, input int y);
        exp_t e;
        e.ch  = ch;
        e.y   = y;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.valid_out) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fails++;
                $display("FAIL spurious_strobe cyc=%0d y=%0d ch=%0d, none expected",
                         cyc, bus.y, bus.ch_out);
            end else begin
                e = q.pop_front();
                n_checks += 2;
                if (bus.y !== DATA_W'(e.y)) begin
                    n_fails++;
                    $display("FAIL y cyc=%0d got %0d want %0d", cyc, bus.y, e.y);
                end
                if (bus.ch_out !== 3'(e.ch)) begin
                    n_fails++;
                    $display("FAIL ch_out cyc=%0d got %0d want %0d",
                             cyc, bus.ch_out, e.ch);
                end
                if (cyc !== e.cyc) begin
                    n_fails++;
                    $display("FAIL latency strobe at cyc %0d want cyc %0d", cyc, e.cyc);
                end
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fails++;
            $display("FAIL missing_strobe cyc=%0d want y=%0d ch=%0d", cyc, e.y, e.ch);
        end
    endtask

    task automatic send(input int ch, input int x);
        bus.valid_in = 1'b1;
        bus.ch_in    = 3'(ch);
        bus.x        = DATA_W'(x);
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic drain(input string name);
        idle(3);
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL %s_drain pending=%0d want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_checks += 3;
        if (bus.valid_out !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_valid got %b want 0", bus.valid_out);
        end
        if (bus.y !== '0) begin
            n_fails++;
            $display("FAIL reset_y got %0d want 0", bus.y);
        end
        if (bus.ch_out !== '0) begin
            n_fails++;
            $display("FAIL reset_ch got %0d want 0", bus.ch_out);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_n1();
        bus.n_avgs_in = 3'd1;
        send(0, 0);
        expect_out(0, 5);
        send(0, 10);
        send(0, 20);
        expect_out(0, 20);
        send(0, 20);
        drain("n1");
        n_checks += 2;
        if (bus.y !== 16'd20) begin
            n_fails++;
            $display("FAIL hold_y got %0d want 20", bus.y);
        end
        if (bus.ch_out !== 3'd0) begin
            n_fails++;
            $display("FAIL hold_ch got %0d want 0", bus.ch_out);
        end
    endtask

    task automatic test_round_robin();
        bus.n_avgs_in = 3'd2;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (i == 3) expect_out(c, 6 + c);
                send(c, 4 * i + c);
            end
        end
        drain("round_robin");
    endtask

    task automatic test_n0();
        bus.n_avgs_in = 3'd0;
        expect_out(2, 7);
        send(2, 7);
        expect_out(2, 9);
        send(2, 9);
        expect_out(2, 3);
        send(2, 3);
        drain("n0");
    endtask

    task automatic test_rounding();
        bus.n_avgs_in = 3'd1;
        send(1, 1);
`ifdef ROUND_EN
        expect_out(1, 2);
`else
        expect_out(1, 1);
`endif
        send(1, 2);
        drain("rounding");
    endtask

    task automatic test_n7_switch();
        bus.n_avgs_in = 3'd7;
        for (int i = 0; i < 128; i++) begin
            if (i == 10) bus.n_avgs_in = 3'd2;
            if (i == 127) expect_out(3, 16'hFFFF);
            send(3, 16'hFFFF);
        end
        send(3, 8);
        send(3, 8);
        send(3, 8);
        expect_out(3, 9);
        send(3, 12);
        drain("n7_switch");
    endtask

    task automatic test_reset_mid();
        bus.n_avgs_in = 3'd1;
        send(0, 100);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        send(0, 4);
        expect_out(0, 5);
        send(0, 6);
        drain("reset_mid");
    endtask

    task automatic test_clear();
        bus.n_avgs_in = 3'd1;
        send(1, 100);
        bus.clear = 1'b1;
        idle(1);
        bus.clear = 1'b0;
        send(1, 4);
        expect_out(1, 5);
        send(1, 6);
        send(2, 50);
        bus.clear = 1'b1;
        send(2, 4);
        bus.clear = 1'b0;
        expect_out(2, 5);
        send(2, 6);
        drain("clear");
    endtask

    task automatic test_bad_ch();
        bus.n_avgs_in = 3'd1;
        send(4, 4);
        send(5, 1000);
        send(7, 1000);
        expect_out(4, 5);
        send(4, 6);
        drain("bad_ch");
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.x         = '0;
        bus.ch_in     = '0;
        bus.n_avgs_in = '0;
        bus.clear     = 1'b0;
        test_reset();
        test_n1();
        test_round_robin();
        test_n0();
        test_rounding();
        test_n7_switch();
        test_reset_mid();
        test_clear();
        test_bad_ch();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
